// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction ROM port, fetch-to-decode handshake and branch redirect.
interface instr_fetch_ctrl_if;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        id_ready;
  logic        br_taken;
  logic [15:0] br_target;

  modport master (
    output rom_addr, if_instr, if_pc, if_valid,
    input  rom_data, id_ready, br_taken, br_target
  );

  modport slave (
    input  rom_addr, if_instr, if_pc, if_valid,
    output rom_data, id_ready, br_taken, br_target
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks a PC through the ROM from RESET_PC to END_PC,
// presenting one registered instruction at a time to decode, with stall and branch redirect.
module instr_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] END_PC   = 16'h0003
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instr_fetch_ctrl_if.master    bus,
  output logic                  halted,
  output logic [15:0]           fetch_cnt
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] pc, pc_d;
  logic [DW-1:0] instr, instr_d;
  logic [AW-1:0] ipc, ipc_d;
  logic          valid, valid_d;
  logic [15:0]   cnt, cnt_d;
  logic          xfer;

  assign xfer = valid & bus.id_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      instr  <= '0;
      ipc    <= '0;
      valid  <= 1'b0;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      instr  <= instr_d;
      ipc    <= ipc_d;
      valid  <= valid_d;
      cnt    <= cnt_d;
      halted <= (state_d == S_HALT);
    end
  end

  // Next-state and datapath update; branch outranks stall, fetch and end detection
  always_comb begin
    state_d = state;
    pc_d    = pc;
    instr_d = instr;
    ipc_d   = ipc;
    valid_d = valid;
    cnt_d   = cnt;

    if (xfer && (cnt != 16'hFFFF)) begin
      cnt_d = cnt + 16'(1);
    end

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.br_taken) begin
          pc_d    = bus.br_target;
          valid_d = 1'b0;
        end else if (!valid || bus.id_ready) begin
          instr_d = bus.rom_data;
          ipc_d   = pc;
          valid_d = 1'b1;
          pc_d    = pc + AW'(1);
          if (pc == END_PC) begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (bus.br_taken) begin
          pc_d    = bus.br_target;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (xfer) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rom_addr = pc;
  assign bus.if_instr = instr;
  assign bus.if_pc    = ipc;
  assign bus.if_valid = valid;
  assign fetch_cnt    = cnt;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios with a transfer scoreboard, plus a
// second instance exercising PC wrap-around.
module tb_instr_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic        halted_a, halted_b;
  logic [15:0] cnt_a, cnt_b;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  instr_fetch_ctrl_if bus_a ();
  instr_fetch_ctrl_if bus_b ();

  instr_fetch_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a.master),
    .halted(halted_a), .fetch_cnt(cnt_a)
  );

  instr_fetch_ctrl #(.RESET_PC(16'hFFFF), .END_PC(16'h0001)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b.master),
    .halted(halted_b), .fetch_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: rom = 32'hF8400081;
      16'h0001: rom = 32'h8B020023;
      16'h0002: rom = 32'hF8401082;
      16'h0003: rom = 32'h8B020023;
      default:  rom = {16'hDEAD, a};
    endcase
  endfunction

  assign bus_a.rom_data = rom(bus_a.rom_addr);
  assign bus_b.rom_data = rom(bus_b.rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pc);
    exp_q.push_back('{pc: pc, instr: rom(pc)});
  endtask

  // Scoreboard monitor: every transfer seen on decode side must match the next expected entry
  always @(negedge clk) begin
    if (rst_n && bus_a.if_valid && bus_a.id_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer_pc", {16'h0, bus_a.if_pc}, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_pc", {16'h0, bus_a.if_pc}, {16'h0, e.pc});
        chk("xfer_instr", bus_a.if_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus_a.id_ready = 1'b1; bus_a.br_taken = 1'b0; bus_a.br_target = 16'h0;
    bus_b.id_ready = 1'b1; bus_b.br_taken = 1'b0; bus_b.br_target = 16'h0;
    #1;
    chk("rst_valid", {31'h0, bus_a.if_valid}, 32'h0);
    chk("rst_instr", bus_a.if_instr, 32'h0);
    chk("rst_rom_addr", {16'h0, bus_a.rom_addr}, 32'h0);
    chk("rst_cnt", {16'h0, cnt_a}, 32'h0);
    chk("rst_halted", {31'h0, halted_a}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_no_fetch", {31'h0, bus_a.if_valid}, 32'h0);

    // Straight run 0..3
    push(16'h0); push(16'h1); push(16'h2); push(16'h3);
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("run_c1_valid", {31'h0, bus_a.if_valid}, 32'h0);
    tick();
    chk("run_c2_valid", {31'h0, bus_a.if_valid}, 32'h1);
    chk("run_c2_pc", {16'h0, bus_a.if_pc}, 32'h0);
    tick(); tick();
    chk("run_pc2_halted", {31'h0, halted_a}, 32'h0);
    tick();
    chk("run_halted", {31'h0, halted_a}, 32'h1);
    chk("run_last_pc", {16'h0, bus_a.if_pc}, 32'h3);
    tick();
    chk("run_cnt", {16'h0, cnt_a}, 32'd4);
    chk("halt_valid_clr", {31'h0, bus_a.if_valid}, 32'h0);
    chk("halt_rom_addr", {16'h0, bus_a.rom_addr}, 32'h4);

    // Stall at if_pc=1
    bus_a.br_taken = 1'b1; bus_a.br_target = 16'h0; tick(); bus_a.br_taken = 1'b0;
    push(16'h0); push(16'h1);
    tick(); tick();
    bus_a.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", {16'h0, bus_a.if_pc}, 32'h1);
      chk("stall_instr", bus_a.if_instr, 32'h8B020023);
      chk("stall_rom_addr", {16'h0, bus_a.rom_addr}, 32'h2);
      chk("stall_cnt", {16'h0, cnt_a}, 32'd5);
    end
    bus_a.id_ready = 1'b1;
    tick();
    chk("release_pc", {16'h0, bus_a.if_pc}, 32'h2);
    bus_a.id_ready = 1'b0;

    // Branch while holding if_pc=2
    bus_a.br_taken = 1'b1; bus_a.br_target = 16'h0;
    tick();
    bus_a.br_taken = 1'b0; bus_a.id_ready = 1'b1;
    chk("br_valid", {31'h0, bus_a.if_valid}, 32'h0);
    chk("br_rom_addr", {16'h0, bus_a.rom_addr}, 32'h0);
    push(16'h0); push(16'h1); push(16'h2); push(16'h3);
    tick();
    chk("br_pc", {16'h0, bus_a.if_pc}, 32'h0);
    chk("br_instr", bus_a.if_instr, 32'hF8400081);
    tick(); tick(); tick(); tick();
    chk("br_run_halted", {31'h0, halted_a}, 32'h1);
    chk("br_run_cnt", {16'h0, cnt_a}, 32'd10);

    // Start ignored in HALT, then branch out of HALT
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("start_in_halt", {31'h0, halted_a}, 32'h1);
    bus_a.br_taken = 1'b1; bus_a.br_target = 16'h2;
    tick();
    bus_a.br_taken = 1'b0;
    chk("exit_halted", {31'h0, halted_a}, 32'h0);
    chk("exit_rom_addr", {16'h0, bus_a.rom_addr}, 32'h2);
    push(16'h2); push(16'h3);
    tick();
    chk("exit_pc2", {16'h0, bus_a.if_pc}, 32'h2);
    tick();
    chk("exit_pc3", {16'h0, bus_a.if_pc}, 32'h3);
    chk("exit_rehalt", {31'h0, halted_a}, 32'h1);
    tick();
    chk("exit_cnt", {16'h0, cnt_a}, 32'd12);

    // Branch coinciding with a transfer still counts it
    bus_a.br_taken = 1'b1; bus_a.br_target = 16'h1; tick(); bus_a.br_taken = 1'b0;
    push(16'h1);
    tick();
    bus_a.br_taken = 1'b1; bus_a.br_target = 16'h1;
    tick();
    bus_a.br_taken = 1'b0; bus_a.id_ready = 1'b0;
    chk("br_xfer_cnt", {16'h0, cnt_a}, 32'd13);
    chk("br_xfer_valid", {31'h0, bus_a.if_valid}, 32'h0);
    tick(); tick();

    // Async reset mid-cycle during a stall
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, bus_a.if_valid}, 32'h0);
    chk("arst_pc", {16'h0, bus_a.if_pc}, 32'h0);
    chk("arst_instr", bus_a.if_instr, 32'h0);
    chk("arst_rom_addr", {16'h0, bus_a.rom_addr}, 32'h0);
    chk("arst_cnt", {16'h0, cnt_a}, 32'h0);
    tick();
    rst_n = 1'b1;
    bus_a.br_taken = 1'b1; bus_a.br_target = 16'h3;
    tick();
    bus_a.br_taken = 1'b0; bus_a.id_ready = 1'b1;
    chk("idle_br_ignored", {16'h0, bus_a.rom_addr}, 32'h0);
    push(16'h0); push(16'h1); push(16'h2); push(16'h3);
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    chk("post_rst_pc", {16'h0, bus_a.if_pc}, 32'h0);
    tick(); tick(); tick(); tick();
    chk("post_rst_cnt", {16'h0, cnt_a}, 32'd4);
    chk("sb_empty", exp_q.size(), 32'd0);

    // Wrap-around instance
    start_b = 1'b1; tick(); start_b = 1'b0;
    tick();
    chk("wrap_pc0", {16'h0, bus_b.if_pc}, 32'hFFFF);
    chk("wrap_instr0", bus_b.if_instr, 32'hDEADFFFF);
    tick();
    chk("wrap_pc1", {16'h0, bus_b.if_pc}, 32'h0000);
    chk("wrap_halted_early", {31'h0, halted_b}, 32'h0);
    tick();
    chk("wrap_pc2", {16'h0, bus_b.if_pc}, 32'h0001);
    chk("wrap_halted", {31'h0, halted_b}, 32'h1);
    chk("wrap_rom_addr", {16'h0, bus_b.rom_addr}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
